// File: rtl/gcd_operand_packer.sv
// Operand packer sitting in front of the GCD unit.
// Collects consecutive 16-bit words as (A, B) and queues packed {A, B}
// requests in a small circular buffer so pairing continues while the GCD
// unit is busy. A pair is visible on ostream the cycle after its B word is
// accepted (no bypass path).
module gcd_operand_packer #(
  parameter int p_nbits       = 16,
  parameter int p_num_entries = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 istream_val,
  output logic                 istream_rdy,
  input  logic [p_nbits-1:0]   istream_msg,
  output logic                 ostream_val,
  input  logic                 ostream_rdy,
  output logic [2*p_nbits-1:0] ostream_msg,
  output logic                 a_pending,
  output logic [15:0]          pair_count
);

  localparam int MW = 2 * p_nbits;
  localparam int PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int CW = $clog2(p_num_entries + 1);
  localparam logic [PW-1:0] LAST  = PW'(p_num_entries - 1);
  localparam logic [CW-1:0] DEPTH = CW'(p_num_entries);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [p_nbits-1:0] a_reg;
  logic [MW-1:0]   mem [p_num_entries];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            in_xfer;
  logic            enq;
  logic            deq;

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Queue side of the datapath: head entry is presented, zero when empty.
  assign ostream_val = (count != '0);
  assign deq         = ostream_val && ostream_rdy;
  assign ostream_msg = ostream_val ? mem[head] : '0;

  // Next-state and input handshake; a full queue still accepts B when the
  // head is leaving in the same cycle, which keeps depth-1 at full rate.
  always_comb begin
    state_next  = WAIT_A;
    istream_rdy = 1'b0;
    a_pending   = 1'b0;
    in_xfer     = 1'b0;
    enq         = 1'b0;
    case (state)
      WAIT_A: begin
        istream_rdy = 1'b1;
      end
      WAIT_B: begin
        a_pending   = 1'b1;
        istream_rdy = (count < DEPTH) || deq;
      end
      default: begin
        istream_rdy = 1'b0;
      end
    endcase
    if (reset) istream_rdy = 1'b0;
    in_xfer = istream_val && istream_rdy;
    case (state)
      WAIT_A:  state_next = in_xfer ? WAIT_B : WAIT_A;
      WAIT_B: begin
        enq        = in_xfer;
        state_next = in_xfer ? WAIT_A : WAIT_B;
      end
      default: state_next = WAIT_A;
    endcase
  end

  // Control state, A holding register, pointers, occupancy and pair counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_A;
      a_reg      <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      pair_count <= '0;
    end else begin
      state <= state_next;
      if ((state == WAIT_A) && in_xfer) a_reg <= istream_msg;
      if (enq) tail <= ptr_inc(tail);
      if (deq) begin
        head       <= ptr_inc(head);
        pair_count <= pair_count + 16'd1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pair storage; entries are only meaningful between tail write and head read.
  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= {a_reg, istream_msg};
  end

endmodule

// File: tb/tb_gcd_operand_packer.sv
// Scoreboard bench for gcd_operand_packer: a word-pairing reference model
// feeds expected {A, B} requests and gcd values into queues; a monitor pops
// and compares whenever the packer delivers a pair.
module tb_gcd_operand_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        istream_val = 1'b0;
  logic        istream_rdy;
  logic [15:0] istream_msg = '0;
  logic        ostream_val;
  logic        ostream_rdy = 1'b0;
  logic [31:0] ostream_msg;
  logic        a_pending;
  logic [15:0] pair_count;

  gcd_operand_packer #(.p_nbits(16), .p_num_entries(2)) dut (
    .clk(clk),
    .reset(reset),
    .istream_val(istream_val),
    .istream_rdy(istream_rdy),
    .istream_msg(istream_msg),
    .ostream_val(ostream_val),
    .ostream_rdy(ostream_rdy),
    .ostream_msg(ostream_msg),
    .a_pending(a_pending),
    .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb_q[$];
  logic [15:0] gcd_q[$];
  logic        have_a = 1'b0;
  logic [15:0] a_word = '0;
  logic [15:0] exp_pairs = '0;
  logic        last_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] gcd16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Reference: every accepted word alternates between A and B roles.
  task automatic model_accept(input logic [15:0] w);
    if (!have_a) begin
      have_a = 1'b1;
      a_word = w;
    end else begin
      have_a = 1'b0;
      sb_q.push_back({a_word, w});
      gcd_q.push_back(gcd16(a_word, w));
    end
  endtask

  task automatic cycle(input logic v, input logic [15:0] m, input logic r);
    @(negedge clk);
    istream_val = v;
    istream_msg = m;
    ostream_rdy = r;
    #1;
    chk("a_pending", a_pending, have_a);
    if (!ostream_val) chk("msg_zero_when_empty", ostream_msg, 32'h0);
    last_rdy = istream_rdy;
    if (v && istream_rdy) model_accept(m);
  endtask

  // Monitor: pop and compare each delivered pair.
  initial begin
    logic [31:0] exp_msg;
    logic [15:0] exp_gcd;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && ostream_val && ostream_rdy) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pair: got %h, expected no pair", ostream_msg);
        end else begin
          exp_msg = sb_q.pop_front();
          exp_gcd = gcd_q.pop_front();
          chk("pair_order", ostream_msg, exp_msg);
          chk("gcd_result", gcd16(ostream_msg[31:16], ostream_msg[15:0]), exp_gcd);
          exp_pairs = exp_pairs + 16'd1;
        end
      end
      chk("count_bound", dut.count <= 2, 1'b1);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_istream_rdy", istream_rdy, 1'b0);
    chk("rst_ostream_val", ostream_val, 1'b0);
    chk("rst_a_pending", a_pending, 1'b0);
    chk("rst_ostream_msg", ostream_msg, 32'h0);
    chk("rst_pair_count", pair_count, 16'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_rdy", istream_rdy, 1'b1);

    // Single pair with one-cycle latency
    cycle(1'b1, 16'h000F, 1'b1);
    cycle(1'b1, 16'h0005, 1'b1);
    chk("no_bypass", ostream_val, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("lat_one_val", ostream_val, 1'b1);
    chk("lat_one_msg", ostream_msg, 32'h000F0005);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("single_pair_count", pair_count, 16'd1);

    // Backpressure fills the queue and holds an A
    for (int i = 1; i <= 5; i++) cycle(1'b1, 16'(i), 1'b0);
    cycle(1'b1, 16'h0006, 1'b0);
    chk("bp_rdy_low", last_rdy, 1'b0);
    chk("bp_a_pending", a_pending, 1'b1);
    chk("bp_held_a", dut.a_reg, 16'h0005);
    chk("bp_full", dut.count, 2);
    // Full queue: simultaneous enqueue and dequeue
    cycle(1'b1, 16'h0006, 1'b1);
    chk("full_simul_rdy", last_rdy, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("full_count_kept", dut.count, 2);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("bp_pair_count", pair_count, 16'd4);
    chk("bp_drained", ostream_val, 1'b0);

    // Asynchronous reset mid-pair
    cycle(1'b1, 16'h1234, 1'b1);
    @(negedge clk);
    istream_val = 1'b0;
    #1;
    chk("pre_rst_a_pending", a_pending, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_a_pending", a_pending, 1'b0);
    chk("async_rdy", istream_rdy, 1'b0);
    have_a = 1'b0;
    sb_q.delete();
    gcd_q.delete();
    exp_pairs = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_pair_count", pair_count, 16'h0);
    cycle(1'b1, 16'h0007, 1'b1);
    cycle(1'b1, 16'h0003, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("midrst_msg", ostream_msg, 32'h00070003);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("midrst_count", pair_count, 16'd1);

    // pair_count wrap
    @(negedge clk);
    force dut.pair_count = 16'hFFFF;
    @(negedge clk);
    release dut.pair_count;
    exp_pairs = 16'hFFFF;
    #1;
    chk("wrap_preload", pair_count, 16'hFFFF);
    cycle(1'b1, 16'h0001, 1'b1);
    cycle(1'b1, 16'h0002, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("wrap_zero", pair_count, 16'h0000);

    // Random operands and stalls
    repeat (600) cycle(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0);
    repeat (8) cycle(1'b0, 16'h0000, 1'b1);
    chk("sb_empty", sb_q.size(), 0);
    chk("final_pair_count", pair_count, exp_pairs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
